// File: rtl/miriscv_lsu_split.sv
// Load/store unit that splits boundary-crossing accesses into two word-aligned bus phases.
// Latency: aligned access valid 3 cycles after accept, split adds 2; kill suppresses the completion pulse.
module miriscv_lsu_split #(
  parameter  int XLEN         = 32,
  parameter  int MISALIGN_EN  = 1,
  localparam int MEM_ACCESS_W = 3
) (
  input  logic                    clk_i,
  input  logic                    arstn_i,
  output logic                    data_req_o,
  input  logic                    data_gnt_i,
  input  logic                    data_rvalid_i,
  input  logic [XLEN-1:0]         data_rdata_i,
  output logic                    data_we_o,
  output logic [XLEN/8-1:0]       data_be_o,
  output logic [XLEN-1:0]         data_addr_o,
  output logic [XLEN-1:0]         data_wdata_o,
  input  logic                    lsu_req_i,
  input  logic                    lsu_kill_i,
  input  logic                    lsu_we_i,
  input  logic [MEM_ACCESS_W-1:0] lsu_size_i,
  input  logic [XLEN-1:0]         lsu_addr_i,
  input  logic [XLEN-1:0]         lsu_data_i,
  output logic [XLEN-1:0]         lsu_data_o,
  output logic                    lsu_valid_o,
  output logic                    lsu_fault_o,
  output logic                    lsu_stall_o
);

  localparam int NB  = XLEN / 8;
  localparam int OW  = $clog2(NB);
  localparam int BEW = 2 * NB;
  localparam int DW  = 2 * XLEN;

  // Size encoding shared with miriscv_lsu_pkg
  localparam logic [MEM_ACCESS_W-1:0] SZ_B  = 3'd0;
  localparam logic [MEM_ACCESS_W-1:0] SZ_H  = 3'd1;
  localparam logic [MEM_ACCESS_W-1:0] SZ_W  = 3'd2;
  localparam logic [MEM_ACCESS_W-1:0] SZ_BU = 3'd4;
  localparam logic [MEM_ACCESS_W-1:0] SZ_HU = 3'd5;

  typedef enum logic [2:0] {IDLE, REQ0, RSP0, REQ1, RSP1, DONE} state_t;

  state_t                  state;
  logic                    kill_q;
  logic [XLEN-1:0]         addr_q;
  logic [MEM_ACCESS_W-1:0] size_q;
  logic                    we_q;
  logic [XLEN-1:0]         data_q;
  logic                    split_q;
  logic                    fault_q;
  logic [XLEN-1:0]         rdata0_q;

  logic [OW-1:0]   off_in, off_q;
  logic [2:0]      sz_in;
  logic            split_d, fault_d, kill_any;
  logic [3:0]      mask4;
  logic [BEW-1:0]  be_full;
  logic [DW-1:0]   wd_full;
  logic [XLEN-1:0] addr0, addr1;
  logic [XLEN-1:0] ld_lo, ld_hi, ld_sh, ld_ext;
  logic            in_req;

  function automatic logic [2:0] size_bytes(input logic [MEM_ACCESS_W-1:0] s);
    case (s)
      SZ_B, SZ_BU: return 3'd1;
      SZ_H, SZ_HU: return 3'd2;
      default:     return 3'd4;
    endcase
  endfunction

  assign off_in   = lsu_addr_i[OW-1:0];
  assign off_q    = addr_q[OW-1:0];
  assign sz_in    = size_bytes(lsu_size_i);
  assign split_d  = (MISALIGN_EN != 0) && ((int'(off_in) + int'(sz_in)) > NB);
  assign fault_d  = !(lsu_size_i inside {SZ_B, SZ_H, SZ_W, SZ_BU, SZ_HU}) ||
                    ((MISALIGN_EN == 0) && ((off_in & OW'(sz_in - 3'd1)) != '0));
  assign kill_any = kill_q | lsu_kill_i;

  always_comb begin
    mask4 = 4'hF;
    case (size_q)
      SZ_B, SZ_BU: mask4 = 4'h1;
      SZ_H, SZ_HU: mask4 = 4'h3;
      default:     mask4 = 4'hF;
    endcase
  end

  // Lanes and data are laid out across a double-width window; each phase takes one half.
  assign be_full = BEW'(mask4) << off_q;
  assign wd_full = DW'(data_q) << {off_q, 3'b000};
  assign addr0   = {addr_q[XLEN-1:OW], {OW{1'b0}}};
  assign addr1   = addr0 + XLEN'(NB);

  assign in_req       = (state == REQ0) || (state == REQ1);
  assign data_req_o   = in_req & ~lsu_kill_i;
  assign data_we_o    = in_req & we_q;
  assign data_addr_o  = !in_req ? '0 : (state == REQ1) ? addr1 : addr0;
  assign data_be_o    = !in_req ? '0 : (state == REQ1) ? be_full[BEW-1:NB] : be_full[NB-1:0];
  assign data_wdata_o = !in_req ? '0 : (state == REQ1) ? wd_full[DW-1:XLEN] : wd_full[XLEN-1:0];

  assign lsu_valid_o = (state == DONE);
  assign lsu_fault_o = (state == DONE) & fault_q;
  assign lsu_stall_o = lsu_req_i & ~lsu_kill_i & (state != DONE);

  always_comb begin
    ld_lo = data_rdata_i;
    ld_hi = '0;
    if (state == RSP1) begin
      ld_lo = rdata0_q;
      ld_hi = data_rdata_i;
    end
  end

  assign ld_sh = XLEN'({ld_hi, ld_lo} >> {off_q, 3'b000});

  always_comb begin
    ld_ext = '0;
    case (size_q)
      SZ_B:    ld_ext = XLEN'($signed(ld_sh[7:0]));
      SZ_BU:   ld_ext = XLEN'(ld_sh[7:0]);
      SZ_H:    ld_ext = XLEN'($signed(ld_sh[15:0]));
      SZ_HU:   ld_ext = XLEN'(ld_sh[15:0]);
      default: ld_ext = XLEN'($signed(ld_sh[31:0]));
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!arstn_i) begin
      state      <= IDLE;
      kill_q     <= 1'b0;
      addr_q     <= '0;
      size_q     <= '0;
      we_q       <= 1'b0;
      data_q     <= '0;
      split_q    <= 1'b0;
      fault_q    <= 1'b0;
      rdata0_q   <= '0;
      lsu_data_o <= '0;
    end else begin
      case (state)
        IDLE: begin
          kill_q <= 1'b0;
          if (lsu_req_i && !lsu_kill_i) begin
            addr_q     <= lsu_addr_i;
            size_q     <= lsu_size_i;
            we_q       <= lsu_we_i;
            data_q     <= lsu_data_i;
            split_q    <= split_d;
            fault_q    <= fault_d;
            lsu_data_o <= '0;
            state      <= fault_d ? DONE : REQ0;
          end
        end
        REQ0: begin
          if (lsu_kill_i)      state <= IDLE;
          else if (data_gnt_i) state <= RSP0;
        end
        RSP0: begin
          if (lsu_kill_i) kill_q <= 1'b1;
          if (data_rvalid_i) begin
            if (kill_any) begin
              state <= IDLE;
            end else if (split_q) begin
              rdata0_q <= data_rdata_i;
              state    <= REQ1;
            end else begin
              if (!we_q) lsu_data_o <= ld_ext;
              state <= DONE;
            end
          end
        end
        REQ1: begin
          if (lsu_kill_i)      state <= IDLE;
          else if (data_gnt_i) state <= RSP1;
        end
        RSP1: begin
          if (lsu_kill_i) kill_q <= 1'b1;
          if (data_rvalid_i) begin
            if (kill_any) begin
              state <= IDLE;
            end else begin
              if (!we_q) lsu_data_o <= ld_ext;
              state <= DONE;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_miriscv_lsu_split.sv
// Directed bench: 32-bit split-capable, 32-bit aligned-only and 64-bit instances driven cycle by cycle.
module tb_miriscv_lsu_split;

  localparam logic [2:0] SZ_B = 3'd0, SZ_H = 3'd1, SZ_W = 3'd2, SZ_BU = 3'd4;

  logic        clk = 1'b0;
  logic        arstn;
  int          checks = 0;
  int          failures = 0;

  // shared 32-bit stimulus
  logic        gnt, rvalid, req, kill, we;
  logic [31:0] rdata, addr, wdat;
  logic [2:0]  size;

  logic        d_req, d_we, d_valid, d_fault, d_stall;
  logic [3:0]  d_be;
  logic [31:0] d_addr, d_wdata, d_data;
  logic        a_req, a_we, a_valid, a_fault, a_stall;
  logic [3:0]  a_be;
  logic [31:0] a_addr, a_wdata, a_data;

  logic        w_gnt, w_rvalid, w_req_i, w_kill, w_we_i;
  logic [63:0] w_rdata, w_addr_i, w_wdat;
  logic [2:0]  w_size;
  logic        w_req, w_we, w_valid, w_fault, w_stall;
  logic [7:0]  w_be;
  logic [63:0] w_addr, w_wdata, w_data;

  always #5 clk = ~clk;

  miriscv_lsu_split u_d (
    .clk_i(clk), .arstn_i(arstn), .data_req_o(d_req), .data_gnt_i(gnt),
    .data_rvalid_i(rvalid), .data_rdata_i(rdata), .data_we_o(d_we), .data_be_o(d_be),
    .data_addr_o(d_addr), .data_wdata_o(d_wdata), .lsu_req_i(req), .lsu_kill_i(kill),
    .lsu_we_i(we), .lsu_size_i(size), .lsu_addr_i(addr), .lsu_data_i(wdat),
    .lsu_data_o(d_data), .lsu_valid_o(d_valid), .lsu_fault_o(d_fault), .lsu_stall_o(d_stall)
  );

  miriscv_lsu_split #(.XLEN(32), .MISALIGN_EN(0)) u_a (
    .clk_i(clk), .arstn_i(arstn), .data_req_o(a_req), .data_gnt_i(gnt),
    .data_rvalid_i(rvalid), .data_rdata_i(rdata), .data_we_o(a_we), .data_be_o(a_be),
    .data_addr_o(a_addr), .data_wdata_o(a_wdata), .lsu_req_i(req), .lsu_kill_i(kill),
    .lsu_we_i(we), .lsu_size_i(size), .lsu_addr_i(addr), .lsu_data_i(wdat),
    .lsu_data_o(a_data), .lsu_valid_o(a_valid), .lsu_fault_o(a_fault), .lsu_stall_o(a_stall)
  );

  miriscv_lsu_split #(.XLEN(64)) u_w (
    .clk_i(clk), .arstn_i(arstn), .data_req_o(w_req), .data_gnt_i(w_gnt),
    .data_rvalid_i(w_rvalid), .data_rdata_i(w_rdata), .data_we_o(w_we), .data_be_o(w_be),
    .data_addr_o(w_addr), .data_wdata_o(w_wdata), .lsu_req_i(w_req_i), .lsu_kill_i(w_kill),
    .lsu_we_i(w_we_i), .lsu_size_i(w_size), .lsu_addr_i(w_addr_i), .lsu_data_i(w_wdat),
    .lsu_data_o(w_data), .lsu_valid_o(w_valid), .lsu_fault_o(w_fault), .lsu_stall_o(w_stall)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    req = 0; kill = 0; gnt = 0; rvalid = 0; we = 0; rdata = '0;
    w_req_i = 0; w_gnt = 0; w_rvalid = 0;
    arstn = 0;
    step();
    arstn = 1;
  endtask

  initial begin
    arstn = 0; gnt = 0; rvalid = 0; req = 0; kill = 0; we = 0;
    rdata = '0; addr = '0; wdat = '0; size = SZ_B;
    w_gnt = 0; w_rvalid = 0; w_req_i = 0; w_kill = 0; w_we_i = 0;
    w_rdata = '0; w_addr_i = '0; w_wdat = '0; w_size = SZ_B;
    step(); step(); settle();
    chk("rst_req", d_req, 0);     chk("rst_we", d_we, 0);
    chk("rst_be", d_be, 0);       chk("rst_addr", d_addr, 0);
    chk("rst_wdata", d_wdata, 0); chk("rst_data", d_data, 0);
    chk("rst_valid", d_valid, 0); chk("rst_fault", d_fault, 0);
    chk("rst_stall", d_stall, 0); chk("rst_w_be", w_be, 0);
    arstn = 1;

    // aligned LW 0x100
    step(); req = 1; size = SZ_W; addr = 32'h100; settle();
    chk("lw_idle_req", d_req, 0); chk("lw_idle_stall", d_stall, 1);
    step(); gnt = 1; settle();
    chk("lw_req", d_req, 1); chk("lw_addr", d_addr, 32'h100);
    chk("lw_be", d_be, 4'hF); chk("lw_we", d_we, 0);
    step(); gnt = 0; rvalid = 1; rdata = 32'h8000_00F0; settle();
    chk("lw_rsp_req", d_req, 0); chk("lw_rsp_valid", d_valid, 0);
    step(); rvalid = 0; settle();
    chk("lw_valid", d_valid, 1); chk("lw_fault", d_fault, 0);
    chk("lw_data", d_data, 32'h8000_00F0); chk("lw_done_stall", d_stall, 0);
    step(); req = 0; settle();
    chk("lw_after_valid", d_valid, 0); chk("lw_no_accept_in_done", d_req, 0);
    chk("lw_data_held", d_data, 32'h8000_00F0);

    // split LH 0x103, phase-1 grant delayed one cycle
    step(); req = 1; size = SZ_H; addr = 32'h103; settle();
    step(); gnt = 1; settle();
    chk("lh_p0_req", d_req, 1); chk("lh_p0_addr", d_addr, 32'h100); chk("lh_p0_be", d_be, 4'h8);
    step(); gnt = 0; rvalid = 1; rdata = 32'h8800_0000; settle();
    chk("lh_rsp0_req", d_req, 0);
    step(); rvalid = 0; rdata = '0; settle();
    chk("lh_p1_req", d_req, 1); chk("lh_p1_addr", d_addr, 32'h104); chk("lh_p1_be", d_be, 4'h1);
    step(); gnt = 1; settle();
    chk("lh_p1_hold_addr", d_addr, 32'h104); chk("lh_p1_hold_req", d_req, 1);
    step(); gnt = 0; rvalid = 1; rdata = 32'h0000_00FF; settle();
    chk("lh_rsp1_valid", d_valid, 0);
    step(); rvalid = 0; req = 0; settle();
    chk("lh_valid", d_valid, 1); chk("lh_fault", d_fault, 0);
    chk("lh_data", d_data, 32'hFFFF_FF88);

    // split SW 0x102
    do_reset();
    step(); req = 1; we = 1; size = SZ_W; addr = 32'h102; wdat = 32'hAABB_CCDD; settle();
    step(); gnt = 1; settle();
    chk("sw_p0_we", d_we, 1); chk("sw_p0_addr", d_addr, 32'h100); chk("sw_p0_be", d_be, 4'hC);
    chk("sw_p0_wdata", d_wdata & 32'hFFFF_0000, 32'hCCDD_0000);
    step(); gnt = 0; rvalid = 1; settle();
    step(); rvalid = 0; gnt = 1; settle();
    chk("sw_p1_we", d_we, 1); chk("sw_p1_addr", d_addr, 32'h104); chk("sw_p1_be", d_be, 4'h3);
    chk("sw_p1_wdata", d_wdata & 32'h0000_FFFF, 32'h0000_AABB);
    step(); gnt = 0; rvalid = 1; settle();
    step(); rvalid = 0; req = 0; we = 0; settle();
    chk("sw_valid", d_valid, 1); chk("sw_fault", d_fault, 0); chk("sw_data", d_data, 0);

    // aligned-only instance faults on LW 0x101; split instance then killed in REQ0
    do_reset();
    step(); req = 1; size = SZ_W; addr = 32'h101; settle();
    chk("mis_req", a_req, 0); chk("mis_stall", a_stall, 1);
    step(); req = 0; settle();
    chk("mis_valid", a_valid, 1); chk("mis_fault", a_fault, 1);
    chk("mis_req_n1", a_req, 0); chk("mis_data", a_data, 0);
    step(); settle();
    chk("mis_valid_off", a_valid, 0); chk("mis_fault_off", a_fault, 0);
    chk("kreq_before", d_req, 1); chk("kreq_addr", d_addr, 32'h100);
    kill = 1; settle();
    chk("kreq_drop", d_req, 0);
    step(); kill = 0; settle();
    chk("kreq_idle_req", d_req, 0); chk("kreq_no_valid", d_valid, 0);
    step(); settle();
    chk("kreq_no_valid2", d_valid, 0);

    // kill in RSP0 of split LH, response two cycles later
    step(); req = 1; size = SZ_H; addr = 32'h103; settle();
    step(); gnt = 1; settle();
    chk("krsp_req", d_req, 1);
    step(); gnt = 0; kill = 1; settle();
    chk("krsp_stall", d_stall, 0); chk("krsp_req_rsp", d_req, 0);
    step(); kill = 0; req = 0; settle();
    step(); rvalid = 1; rdata = 32'h8800_0000; settle();
    chk("krsp_rv_req", d_req, 0);
    step(); rvalid = 0; settle();
    chk("krsp_no_req1", d_req, 0); chk("krsp_no_valid", d_valid, 0);
    gnt = 1; rvalid = 1; settle();
    step(); gnt = 0; rvalid = 0; settle();
    chk("stray_valid", d_valid, 0); chk("stray_req", d_req, 0);

    // fresh LW after kill, then illegal size
    step(); req = 1; size = SZ_W; addr = 32'h200; settle();
    step(); gnt = 1; settle();
    chk("lw2_addr", d_addr, 32'h200); chk("lw2_req", d_req, 1);
    step(); gnt = 0; rvalid = 1; rdata = 32'h1234_5678; settle();
    step(); rvalid = 0; req = 0; settle();
    chk("lw2_valid", d_valid, 1); chk("lw2_data", d_data, 32'h1234_5678);
    step(); req = 1; size = 3'd3; addr = 32'h100; settle();
    step(); req = 0; settle();
    chk("ill_valid", d_valid, 1); chk("ill_fault", d_fault, 1);
    chk("ill_req", d_req, 0); chk("ill_data", d_data, 0);

    // reset while waiting for a response
    step(); req = 1; size = SZ_W; addr = 32'h300; settle();
    step(); gnt = 1; settle();
    step(); gnt = 0; arstn = 0; settle();
    step(); arstn = 1; req = 0; settle();
    chk("rmid_req", d_req, 0); chk("rmid_addr", d_addr, 0);
    rvalid = 1; rdata = 32'hDEAD_BEEF;
    step(); rvalid = 0; settle();
    chk("rmid_valid", d_valid, 0); chk("rmid_data", d_data, 0);

    // 64-bit: LBU 0x7 and sign-extended LW 0x4
    step(); w_req_i = 1; w_size = SZ_BU; w_addr_i = 64'h7; settle();
    step(); w_gnt = 1; settle();
    chk("lbu64_req", w_req, 1); chk("lbu64_addr", w_addr, 64'h0); chk("lbu64_be", w_be, 8'h80);
    step(); w_gnt = 0; w_rvalid = 1; w_rdata = 64'hAB00_0000_0000_0000; settle();
    step(); w_rvalid = 0; w_req_i = 0; settle();
    chk("lbu64_valid", w_valid, 1); chk("lbu64_data", w_data, 64'h0000_0000_0000_00AB);
    step(); w_req_i = 1; w_size = SZ_W; w_addr_i = 64'h4; settle();
    step(); w_gnt = 1; settle();
    chk("lw64_be", w_be, 8'hF0);
    step(); w_gnt = 0; w_rvalid = 1; w_rdata = 64'h8000_0000_0000_0000; settle();
    step(); w_rvalid = 0; w_req_i = 0; settle();
    chk("lw64_valid", w_valid, 1); chk("lw64_data", w_data, 64'hFFFF_FFFF_8000_0000);
    chk("lw64_fault", w_fault, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/miriscv_lsu_split.md
MIRISCV_LSU_SPLIT -- requirements
Module: miriscv_lsu_split

Interface
REQ-001 SHALL have parameter XLEN, default 32, data/address width; legal values 32 and 64.
REQ-002 SHALL have parameter MISALIGN_EN, default 1; 1 = split boundary-crossing accesses, 0 = raise fault on any non-naturally-aligned access.
REQ-003 SHALL have ports:
  clk_i  in  1  clock, all state on rising edge.
  arstn_i  in  1  reset, synchronous, active-low.
  data_req_o  out  1  memory request.
  data_gnt_i  in  1  memory accepted request this cycle.
  data_rvalid_i  in  1  response valid.
  data_rdata_i  in  XLEN  read data.
  data_we_o  out  1  write enable.
  data_be_o  out  XLEN/8  byte enables.
  data_addr_o  out  XLEN  word-aligned address.
  data_wdata_o  out  XLEN  lane-aligned write data.
  lsu_req_i  in  1  core access request, held while stalled.
  lsu_kill_i  in  1  cancel current access.
  lsu_we_i  in  1  store when 1.
  lsu_size_i  in  MEM_ACCESS_W  miriscv_lsu_pkg size encoding.
  lsu_addr_i  in  XLEN  byte address.
  lsu_data_i  in  XLEN  store data, LSB-justified.
  lsu_data_o  out  XLEN  extended load result.
  lsu_valid_o  out  1  access complete, one-cycle pulse.
  lsu_fault_o  out  1  misaligned/illegal size, qualified by lsu_valid_o.
  lsu_stall_o  out  1  core must hold pipeline.

Function
REQ-004 SHALL implement FSM IDLE, REQ0, RSP0, REQ1, RSP1, DONE.
REQ-005 IDLE: accept when lsu_req_i & ~lsu_kill_i; latch addr, size, we, data; next REQ0 (legal) or DONE with fault (illegal).
REQ-006 Fault conditions: size encoding not BYTE/UBYTE/HALF/UHALF/WORD; or MISALIGN_EN=0 and addr not multiple of access size.
REQ-007 Split condition: (addr mod XLEN/8) + size_bytes > XLEN/8; only when MISALIGN_EN=1.
REQ-008 REQ0/REQ1: data_req_o = 1 & ~lsu_kill_i; hold addr/be/we/wdata stable until data_gnt_i; on gnt go RSP0/RSP1.
REQ-009 RSP0 on data_rvalid_i: split -> REQ1, else -> DONE; RSP1 on data_rvalid_i -> DONE.
REQ-010 DONE: lsu_valid_o = 1 for exactly one cycle, then IDLE; no acceptance in DONE even if lsu_req_i high.
REQ-011 Phase-0 address = latched addr with low log2(XLEN/8) bits zero; phase-1 address = phase-0 + XLEN/8, wrapping modulo 2^XLEN.
REQ-012 Byte enables: mask of size_bytes ones shifted left by offset over 2*XLEN/8 lanes; phase 0 drives low half, phase 1 high half.
REQ-013 Write data: lsu_data_i shifted left by 8*offset across 2*XLEN bits; phase 0 low XLEN bits, phase 1 high XLEN bits.
REQ-014 Load data: phase-0 rdata captured in register; result = ({phase1_rdata, phase0_rdata} >> 8*offset) truncated to size, sign-extended (BYTE/HALF, and WORD when XLEN=64) or zero-extended (UBYTE/UHALF).
REQ-015 lsu_data_o SHALL be registered, valid from DONE cycle, held until next accept; stores and faults drive 0.
REQ-016 lsu_stall_o = lsu_req_i & ~lsu_kill_i & (state != DONE).
REQ-017 lsu_kill_i in REQx before gnt: data_req_o drops same cycle, next IDLE, no lsu_valid_o.
REQ-018 lsu_kill_i in RSPx or while kill pending: set pending flag; on data_rvalid_i go IDLE, skip phase 1, no lsu_valid_o; flag cleared on IDLE.
REQ-019 data_gnt_i and data_rvalid_i outside REQx/RSPx respectively SHALL be ignored.
REQ-020 Latency aligned access, gnt same cycle, rvalid next: accept cycle N, req N+1, rvalid N+2, lsu_valid_o N+3; split adds 2 cycles.

Reset
REQ-021 arstn_i low at clock edge: state IDLE, kill flag 0, all latched registers 0.
REQ-022 Reset values: data_req_o 0, data_we_o 0, data_be_o 0, data_addr_o 0, data_wdata_o 0, lsu_data_o 0, lsu_valid_o 0, lsu_fault_o 0; lsu_stall_o follows REQ-016.
REQ-023 Reset mid-transaction SHALL abandon it; later rvalid ignored per REQ-019.

Verification
REQ-024 XLEN=32, LW addr 0x100, rdata 0x8000_00F0 -> one req addr 0x100 be 0xF, lsu_data_o 0x8000_00F0 at N+3.
REQ-025 XLEN=32, LH addr 0x103, rdata 0x8800_0000 then 0x0000_00FF -> reqs 0x100 be 0x8, 0x104 be 0x1, lsu_data_o 0xFFFF_FF88.
REQ-026 XLEN=32, SW addr 0x102 data 0xAABB_CCDD -> 0x100 be 0xC wdata 0xCCDD_xxxx, 0x104 be 0x3 wdata 0xxxxx_AABB.
REQ-027 MISALIGN_EN=0, LW addr 0x101 -> no data_req_o, lsu_valid_o & lsu_fault_o at N+1.
REQ-028 XLEN=64, LBU addr 0x7 rdata 0xAB00_..._00 -> be 0x80, lsu_data_o 0x0000_0000_0000_00AB.
REQ-029 Kill in RSP0 of split load, rvalid 2 cycles later -> no REQ1, no lsu_valid_o, IDLE after rvalid.
